addkey_lane: RTL and testbench

ADDKEY_LANE -- requirements
Module: addkey_lane

---
 rtl/addkey_pkg.sv | 13 +
 rtl/addkey_lane_slice.sv | 20 ++
 rtl/addkey_lane.sv | 96 +++++++++
 tb/tb_addkey_lane.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/addkey_pkg.sv
// Shared types and default widths for the lane-serial AddRoundKey block.
package addkey_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_LANE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addkey_lane_slice.sv
// Combinational lane step: XORs one LANE_W-wide lane of the working block with
// the matching key lane and returns the block with only that lane replaced.
module addkey_lane_slice #(
  parameter int DATA_W = addkey_pkg::DEF_DATA_W,
  parameter int LANE_W = addkey_pkg::DEF_LANE_W,
  parameter int CNT_W  = 2
) (
  input  logic [DATA_W-1:0] state,
  input  logic [DATA_W-1:0] key,
  input  logic [CNT_W-1:0]  cnt,
  output logic [DATA_W-1:0] next_state
);

  // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_state[cnt*LANE_W +: LANE_W] = state[cnt*LANE_W +: LANE_W] ^ key[cnt*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/addkey_lane.sv
// AddRoundKey processed one lane per clock; the result register only updates
// when the last lane completes, so partial blocks are never visible.
module addkey_lane
  import addkey_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              finish,
  output logic [DATA_W-1:0] addkey
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam int CNT_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NLANES - 1);

  if (DATA_W % LANE_W != 0) begin : g_bad_width
    $error("addkey_lane: DATA_W must be a multiple of LANE_W");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] addkey_q, addkey_d;
  logic [DATA_W-1:0] lane_next;

  addkey_lane_slice #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W),
    .CNT_W  (CNT_W)
  ) u_slice (
    .state      (data_q),
    .key        (key_q),
    .cnt        (cnt_q),
    .next_state (lane_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    key_d    = key_q;
    addkey_d = addkey_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          data_d  = in;
          key_d   = key;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands are frozen while running; start and new inputs are ignored here.
        data_d = lane_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_LANE) begin
          addkey_d = lane_next;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured operands are cleared on reset too, so no stale key survives an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      key_q    <= '0;
      addkey_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      key_q    <= key_d;
      addkey_q <= addkey_d;
    end
  end

  // Flags decode directly from the registered state, which keeps them exclusive.
  assign busy   = (state_q == RUN);
  assign finish = (state_q == DONE);
  assign addkey = addkey_q;

endmodule

// File: tb/tb_addkey_lane.sv
// Scoreboard bench for addkey_lane at lane widths 32, 128 and 8 on a 128-bit block.
module tb_addkey_lane;

  localparam int NDUT = 3;

  typedef struct {
    logic [127:0] exp;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start  [NDUT];
  logic [127:0] din    [NDUT];
  logic [127:0] key    [NDUT];
  logic         busy   [NDUT];
  logic         fin    [NDUT];
  logic [127:0] addkey [NDUT];

  exp_t q [NDUT][$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  localparam logic [127:0] KEY_A = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] IN_A  = 128'h2a179373117e3de9969f402ee2bec16b;
  localparam logic [127:0] EXP_A = 128'h16585c7a996bca42304dee06f4abbf40;
  localparam logic [127:0] IN_B  = 128'h518eaf45ac6fb79e9cac031e578a2dae;
  localparam logic [127:0] EXP_B = 128'h6dc1604c247a40353a7ead36419f5385;
  localparam logic [127:0] IN_X  = 128'hef520a1a19c1fbe511e45ca3461cc830;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    addkey_lane #(
      .DATA_W (128),
      .LANE_W ((g == 0) ? 32 : (g == 1) ? 128 : 8)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start[g]),
      .in     (din[g]),
      .key    (key[g]),
      .busy   (busy[g]),
      .finish (fin[g]),
      .addkey (addkey[g])
    );
  end

  function automatic int nlanes(int i);
    return 128 / ((i == 0) ? 32 : (i == 1) ? 128 : 8);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic         fin_p [NDUT] = '{default: 1'b0};
  logic [127:0] ak_p  [NDUT] = '{default: '0};
  logic         rst_p = 1'b1;
  exp_t         mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("busy_finish_excl[%0d]", i), 128'(busy[i] & fin[i]), 128'd0);
      if (fin[i] && !fin_p[i]) begin
        if (q[i].size() == 0) begin
          check($sformatf("unexpected_finish[%0d]", i), 128'd1, 128'd0);
        end else begin
          mon_e = q[i].pop_front();
          check($sformatf("result[%0d]", i), addkey[i], mon_e.exp);
          check($sformatf("latency[%0d]", i), 128'(cyc), 128'(mon_e.due));
        end
      end else if (!(rst || rst_p) && addkey[i] !== ak_p[i]) begin
        check($sformatf("addkey_stable[%0d]", i), addkey[i], ak_p[i]);
      end
      fin_p[i] = fin[i];
      ak_p[i]  = addkey[i];
    end
    rst_p = rst;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int i, logic [127:0] v_in, logic [127:0] v_key,
                        logic [127:0] v_exp, bit push);
    din[i]   = v_in;
    key[i]   = v_key;
    start[i] = 1'b1;
    if (push) q[i].push_back('{exp: v_exp, due: cyc + 1 + nlanes(i)});
  endtask

  task automatic wait_fin(int i, int budget);
    int n;
    n = 0;
    while (!fin[i] && n < budget) begin
      tick();
      n++;
    end
    if (!fin[i]) check($sformatf("timeout[%0d]", i), 128'd0, 128'd1);
  endtask

  logic [127:0] b2b_in  [4];
  logic [127:0] b2b_key [4];
  logic [127:0] b2b_exp [4];

  initial begin
    b2b_in[0] = '0;                                       b2b_key[0] = '1;
    b2b_exp[0] = '1;
    b2b_in[1] = {4{32'ha5a5a5a5}};                         b2b_key[1] = '1;
    b2b_exp[1] = {4{32'h5a5a5a5a}};
    b2b_in[2] = 128'h00000000_11111111_22222222_33333333;
    b2b_key[2] = 128'h01234567_89abcdef_fedcba98_76543210;
    b2b_exp[2] = 128'h01234567_98badcfe_dcfe98ba_45670123;
    b2b_in[3] = KEY_A;                                     b2b_key[3] = IN_A;
    b2b_exp[3] = EXP_A;

    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      start[i] = 1'b0;
      din[i]   = '0;
      key[i]   = '0;
    end
    tick();
    tick();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("reset_busy[%0d]", i), 128'(busy[i]), 128'd0);
      check($sformatf("reset_finish[%0d]", i), 128'(fin[i]), 128'd0);
      check($sformatf("reset_addkey[%0d]", i), addkey[i], 128'd0);
    end

    // Start presented on the first edge after reset release; inputs scrambled after capture.
    rst = 1'b0;
    launch(0, IN_A, KEY_A, EXP_A, 1'b1);
    launch(1, IN_B, KEY_A, EXP_B, 1'b1);
    launch(2, IN_B, KEY_A, EXP_B, 1'b1);
    tick();
    for (int i = 0; i < NDUT; i++) begin
      start[i] = 1'b0;
      din[i]   = ~din[i];
      key[i]   = ~key[i];
    end
    wait_fin(2, 40);

    // Idle in DONE for 50 cycles.
    for (int n = 0; n < 50; n++) tick();
    for (int i = 0; i < NDUT; i++) check($sformatf("done_hold[%0d]", i), 128'(fin[i]), 128'd1);
    check("idle_addkey0", addkey[0], EXP_A);
    check("idle_addkey2", addkey[2], EXP_B);

    // Re-pulse start and change inputs mid-run.
    launch(0, IN_B, KEY_A, EXP_B, 1'b1);
    tick();
    start[0] = 1'b0;
    tick();
    start[0] = 1'b1;
    din[0]   = IN_X;
    tick();
    start[0] = 1'b0;
    check("midrun_addkey", addkey[0], EXP_A);
    check("midrun_busy", 128'(busy[0]), 128'd1);
    wait_fin(0, 20);

    // Back-to-back operations with start held high.
    launch(0, b2b_in[0], b2b_key[0], b2b_exp[0], 1'b1);
    for (int k = 1; k < 4; k++) begin
      tick();
      wait_fin(0, 20);
      launch(0, b2b_in[k], b2b_key[k], b2b_exp[k], 1'b1);
      tick();
      check($sformatf("b2b_finish_drop[%0d]", k), 128'(fin[0]), 128'd0);
      check($sformatf("b2b_busy[%0d]", k), 128'(busy[0]), 128'd1);
    end
    start[0] = 1'b0;
    wait_fin(0, 20);
    tick();

    // Abort at lane 2 of 4: no result may ever appear for this operation.
    launch(0, IN_B, KEY_A, EXP_B, 1'b0);
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 128'(busy[0]), 128'd0);
    check("abort_finish", 128'(fin[0]), 128'd0);
    check("abort_addkey", addkey[0], 128'd0);
    for (int n = 0; n < 10; n++) tick();
    check("abort_no_finish", 128'(fin[0]), 128'd0);

    for (int i = 0; i < NDUT; i++)
      check($sformatf("queue_drained[%0d]", i), 128'(q[i].size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
